fft_pulse_window: RTL

- Converts a single-cycle strobe into a level window of programmable delay and length. It is the inverse of the FFT unit's edge detector, which turns levels into pulses.
- Used in the FFT unit to turn one-cycle start/valid strobes into stage-enable or "busy" levels. Example: hold a butterfly-stage enable high for 8 cycles per 8-point frame.
- Also emits one-cycle rise/fall markers so downstream logic needs no extra edge detectors.

---
 rtl/fft_pulse_window_if.sv | 32 +++
 rtl/fft_pulse_window.sv | 118 +++++++++++
 2 files changed

// File: rtl/fft_pulse_window_if.sv
// ============================================================================
//  Module   : fft_pulse_window_if
//  Brief    : Strobe/parameter inputs and window outputs of fft_pulse_window.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fft_pulse_window_if #(
    parameter int CNT_W = 8
);
    logic             i_pulse;
    logic [CNT_W-1:0] i_delay;
    logic [CNT_W-1:0] i_len;
    logic             i_abort;
    logic             o_signal;
    logic             o_busy;
    logic             o_rise;
    logic             o_done;
    logic             o_drop;

    modport master (
        output i_pulse, i_delay, i_len, i_abort,
        input  o_signal, o_busy, o_rise, o_done, o_drop
    );

    modport slave (
        input  i_pulse, i_delay, i_len, i_abort,
        output o_signal, o_busy, o_rise, o_done, o_drop
    );
endinterface

`default_nettype wire

// File: rtl/fft_pulse_window.sv
// ============================================================================
//  Module   : fft_pulse_window
//  Brief    : Turns a one-cycle strobe into a delayed window of programmable
//             length, with registered rise/done/drop markers.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fft_pulse_window #(
    parameter int CNT_W  = 8,
    parameter bit RETRIG = 1'b0
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    fft_pulse_window_if.slave bus
);
    localparam logic [1:0]       c_IDLE   = 2'd0;
    localparam logic [1:0]       c_DELAY  = 2'd1;
    localparam logic [1:0]       c_ACTIVE = 2'd2;
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_nxt;
    logic             r_signal;
    logic             r_busy;
    logic             r_rise;
    logic             r_done;
    logic             r_drop;
    logic             w_busy_now;
    logic             w_accept;
    logic             w_reject;
    logic             w_sig_nxt;

    always_comb begin
        w_busy_now  = (r_state != c_IDLE);
        w_accept    = bus.i_pulse && !bus.i_abort && (bus.i_len != '0) &&
                      (!w_busy_now || RETRIG);
        // An abort swallows a same-cycle strobe without reporting it.
        w_reject    = bus.i_pulse && !bus.i_abort && !w_accept;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        if (bus.i_abort) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_accept) begin
            w_len_nxt = bus.i_len;
            if (bus.i_delay == '0) begin
                w_state_nxt = c_ACTIVE;
                w_cnt_nxt   = bus.i_len;
            end else begin
                w_state_nxt = c_DELAY;
                w_cnt_nxt   = bus.i_delay;
            end
        end else begin
            case (r_state)
                c_DELAY: begin
                    if (r_cnt == c_ONE) begin
                        w_state_nxt = c_ACTIVE;
                        w_cnt_nxt   = r_len;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                    end
                end
                c_ACTIVE: begin
                    if (r_cnt == c_ONE) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
        w_sig_nxt = (w_state_nxt == c_ACTIVE);
    end

    // Markers compare the next window level against the current one so they
    // line up with the first high / first low cycle of o_signal.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_signal <= 1'b0;
            r_busy   <= 1'b0;
            r_rise   <= 1'b0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
            r_signal <= w_sig_nxt;
            r_busy   <= (w_state_nxt != c_IDLE);
            r_rise   <= w_sig_nxt && !r_signal;
            r_done   <= !w_sig_nxt && r_signal;
            r_drop   <= w_reject;
        end
    end

    assign bus.o_signal = r_signal;
    assign bus.o_busy   = r_busy;
    assign bus.o_rise   = r_rise;
    assign bus.o_done   = r_done;
    assign bus.o_drop   = r_drop;

endmodule

`default_nettype wire
